load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of both request and memory sides.
REQ-002 Parameter DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 Parameter TIMEOUT, default 16, maximum WAIT cycles before a load is aborted.
REQ-004 clk  in  1  single clock; all state SHALL update on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  pipeline load/store request.
REQ-007 req_we  in  1  1=store, 0=load.
REQ-008 req_funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 req_addr  in  ADDR_WIDTH  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 req_ready  out  1  high only in IDLE; a request is accepted when req_valid&req_ready.
REQ-012 stall  out  1  high whenever state != IDLE.
REQ-013 resp_valid  out  1  one-cycle completion pulse.
REQ-014 resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores and errors.
REQ-015 resp_err  out  1  misaligned, illegal funct3 or timeout; valid with resp_valid.
REQ-016 mem_req, mem_we  out  1 each  memory request and write strobe.
REQ-017 mem_addr  out  ADDR_WIDTH  word-aligned address (req_addr & ~3).
REQ-018 mem_be  out  4  byte enables; mem_wdata  out  32  lane-replicated store data.
REQ-019 mem_gnt, mem_rvalid  in  1 each; mem_rdata  in  32  memory accept, read-data valid, read word.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, RESP.
REQ-021 IDLE: on accept, register we/funct3/addr/wdata; legal -> REQ, illegal -> RESP with resp_err=1.
REQ-022 Illegal: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; funct3 011/110/111 loads, 011-111 stores.
REQ-023 REQ: mem_req=1 held, outputs stable, until mem_gnt; on gnt store -> RESP, load -> WAIT.
REQ-024 mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; loads drive 4'b1111.
REQ-025 mem_wdata: byte replicated x4, half replicated x2, word unchanged.
REQ-026 WAIT: counter from 0 increments each cycle; mem_rvalid -> latch extracted data, RESP; counter==TIMEOUT-1 without rvalid -> RESP, resp_err=1, rdata 0.
REQ-027 Load extract: mem_rdata >> 8*addr[1:0]; LB/LH sign-extend bit 7/15, LBU/LHU zero-extend, LW unchanged.
REQ-028 RESP: resp_valid=1 exactly one cycle, then IDLE; mem_rvalid outside WAIT SHALL be ignored.
REQ-029 Latency (gnt in first REQ cycle, rvalid next cycle): store resp_valid 2 cycles after accept, load 3.
REQ-030 req_valid while stall=1 SHALL be ignored; mem_gnt outside REQ SHALL be ignored.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, counter 0, and every output 0 except req_ready=1.
REQ-032 Reset mid-transaction SHALL drop mem_req without emitting resp_valid; the transaction is lost.

Structure
REQ-033 Package lsu_pkg SHALL hold funct3 constants (LB..LHU, SB..SW) and the FSM state enum.
REQ-034 Sub-module lsu_load_align SHALL implement REQ-027 combinationally; all else in load_store_unit.

Verification
REQ-035 SW 0xDEADBEEF @0x10, gnt immediate -> mem_be=1111, mem_addr=0x10, resp_valid 2 cycles after accept, err=0.
REQ-036 LB @0x13, mem_rdata=0x80000000 -> resp_rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 SH 0x1234 @0x06 -> mem_be=1100, mem_wdata=0x12341234, mem_addr=0x04.
REQ-038 LW @0x02 -> no mem_req, resp_valid next cycle with resp_err=1, rdata=0.
REQ-039 LW, gnt delayed 3 cycles, no rvalid -> mem_req held stable; resp_err=1 after 16 WAIT cycles.
REQ-040 rst_n low during WAIT -> mem_req/stall 0 immediately, no resp_valid, next request serviced normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 codes, FSM states
// and the legality rule applied to every accepted request.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   // Unknown funct3 codes and accesses that straddle their natural alignment
   // are rejected before any memory traffic is generated.
   function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] off);
      logic bad;
      bad = 1'b1;
      if (we) begin
         case (f3)
            F3_SB:   bad = 1'b0;
            F3_SH:   bad = off[0];
            F3_SW:   bad = (off != 2'b00);
            default: bad = 1'b1;
         endcase
      end else begin
         case (f3)
            F3_LB, F3_LBU: bad = 1'b0;
            F3_LH, F3_LHU: bad = off[0];
            F3_LW:         bad = (off != 2'b00);
            default:       bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Moves the addressed byte/half of a read word down to bit 0 and applies
// sign or zero extension according to the load type.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  byte_off_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   assign shifted = rdata_i >> {byte_off_i, 3'b000};

   // Extension selected by load type; LW passes the word through.
   always_comb begin
      data_o = shifted;
      case (funct3_i)
         F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_LBU:  data_o = {24'd0, shifted[7:0]};
         F3_LHU:  data_o = {16'd0, shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the pipeline and a simple
// request/grant memory port. Stores complete on grant, loads on read-valid
// or after a bounded wait.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; the only state that accepts one
// REQ     | mem_req held with stable address/strobes until mem_gnt
// WAIT    | load granted, waiting for mem_rvalid or timeout
// RESP    | one-cycle resp_valid pulse, then back to IDLE
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  stall,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   lsu_state_e            state_q, state_d;
   logic                  we_q, we_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [31:0]           load_data;

   lsu_load_align u_align (
      .funct3_i   (funct3_q),
      .byte_off_i (addr_q[1:0]),
      .rdata_i    (mem_rdata),
      .data_o     (load_data)
   );

   // State and transaction registers; reset abandons any transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // Next-state logic; gnt and rvalid only matter in their own states.
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               rdata_d  = '0;
               cnt_d    = '0;
               if (is_illegal(req_we, req_funct3, req_addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (mem_gnt) begin
               cnt_d   = '0;
               state_d = we_q ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               rdata_d = load_data;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign stall      = (state_q != ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
   assign resp_err   = (state_q == ST_RESP) & err_q;
   assign mem_req    = (state_q == ST_REQ);

   // Memory-side address, strobes and lane-replicated store data, REQ only.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = 4'b0000;
      mem_wdata = '0;
      if (state_q == ST_REQ) begin
         mem_we   = we_q;
         mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
         if (!we_q) begin
            mem_be = 4'b1111;
         end else begin
            case (funct3_q[1:0])
               2'b00: begin
                  mem_be    = 4'b0001 << addr_q[1:0];
                  mem_wdata = {4{wdata_q[7:0]}};
               end
               2'b01: begin
                  mem_be    = 4'b0011 << {addr_q[1], 1'b0};
                  mem_wdata = {2{wdata_q[15:0]}};
               end
               default: begin
                  mem_be    = 4'b1111;
                  mem_wdata = wdata_q;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed corner cases followed by randomized
// transactions against a byte-lane reference model and a scripted memory.
module tb_load_store_unit;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, stall, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .stall(stall),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // ---- reference model: access size in bytes drives every rule ----
   function automatic int m_bytes(input int f3);
      return 1 << (f3 % 4);
   endfunction

   function automatic bit m_illegal(input bit we, input int f3, input int off);
      if (we && f3 > 2) return 1'b1;
      if (!we && (f3 == 3 || f3 >= 6)) return 1'b1;
      return (off % m_bytes(f3)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input bit we, input int f3, input int off);
      int n;
      if (!we) return 4'hF;
      n = m_bytes(f3);
      return 4'(((1 << n) - 1) << off);
   endfunction

   function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] wd);
      logic [31:0] r;
      int n;
      n = m_bytes(f3);
      r = 0;
      for (int lane = 0; lane < 4; lane++)
         r = r | (((wd >> (8 * (lane % n))) & 32'hFF) << (8 * lane));
      return r;
   endfunction

   function automatic logic [31:0] m_load(input int f3, input int off, input logic [31:0] word);
      logic [31:0] v;
      int n;
      n = m_bytes(f3);
      v = word >> (8 * off);
      if (n < 4) begin
         v = v % (32'd1 << (8 * n));
         if (f3 < 4 && v >= (32'd1 << (8 * n - 1)))
            v = v - (32'd1 << (8 * n));
      end
      return v;
   endfunction

   // One request through the DUT with a scripted memory: grant after gdly
   // REQ cycles, read-valid after rdly WAIT cycles (rdly < 0: never).
   task automatic run_txn(input string tag, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gdly, input int rdly, input logic [31:0] rword);
      bit          ill, rv_ok, got, granted;
      int          exp_lat, k, req_cyc, wait_cyc, off;
      logic [31:0] exp_rd;
      bit          exp_err;
      off     = int'(addr[1:0]);
      ill     = m_illegal(we, int'(f3), off);
      rv_ok   = (rdly >= 0) && (rdly < TO);
      exp_lat = ill ? 1 : we ? 2 + gdly : rv_ok ? 3 + gdly + rdly : 2 + gdly + TO;
      exp_err = ill || (!we && !rv_ok);
      exp_rd  = (exp_err || we) ? 32'd0 : m_load(int'(f3), off, rword);

      @(negedge clk);
      check_eq({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(negedge clk);
      // Garbage request while stalled must be ignored.
      req_valid  = ($urandom_range(0, 1) == 1);
      req_we     = ~we;
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      k = 1; req_cyc = 0; wait_cyc = 0; got = 0; granted = 0;
      while (k <= exp_lat + 4 && !got) begin
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (resp_valid) begin
            got = 1;
            check_eq({tag, ".lat"}, k, exp_lat);
            check_eq({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
            check_eq({tag, ".rdata"}, resp_rdata, exp_rd);
            check_eq({tag, ".stall"}, {31'd0, stall}, 32'd1);
         end else if (mem_req) begin
            check_eq({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
            check_eq({tag, ".be"}, {28'd0, mem_be}, {28'd0, m_be(we, int'(f3), off)});
            check_eq({tag, ".we"}, {31'd0, mem_we}, {31'd0, we});
            if (we) check_eq({tag, ".wdata"}, mem_wdata, m_wdata(int'(f3), wd));
            if (req_cyc == gdly) begin
               mem_gnt = 1'b1;
               granted = 1;
            end else begin
               mem_rvalid = ($urandom_range(0, 1) == 1);
            end
            req_cyc++;
         end else if (granted && !we) begin
            if (wait_cyc == rdly) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rword;
            end else begin
               mem_gnt = ($urandom_range(0, 1) == 1);
            end
            wait_cyc++;
         end
         if (!got) begin
            @(negedge clk);
            k++;
         end
      end
      check_eq({tag, ".resp_seen"}, {31'd0, got}, 32'd1);
      check_eq({tag, ".req_cycles"}, req_cyc, ill ? 0 : gdly + 1);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      req_valid  = 1'b0;
      @(negedge clk);
      check_eq({tag, ".pulse_end"}, {31'd0, resp_valid}, 32'd0);
      check_eq({tag, ".back_idle"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      int gd, rd, pick;
      bit we;
      logic [2:0] f3;
      logic [31:0] a;
      rst_n = 1'b0;
      req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      #12;
      check_eq("rst.ready", {31'd0, req_ready}, 32'd1);
      check_eq("rst.stall", {31'd0, stall}, 32'd0);
      check_eq("rst.mem_req", {31'd0, mem_req}, 32'd0);
      check_eq("rst.resp", {31'd0, resp_valid}, 32'd0);
      check_eq("rst.be", {28'd0, mem_be}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_txn("sw",      1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0);
      run_txn("lb",      0, 3'b000, 32'h13, 0, 0, 0, 32'h80000000);
      run_txn("lbu",     0, 3'b100, 32'h13, 0, 0, 0, 32'h80000000);
      run_txn("sh",      1, 3'b001, 32'h06, 32'h1234, 0, 0, 0);
      run_txn("lw_mis",  0, 3'b010, 32'h02, 0, 0, 0, 0);
      run_txn("lw_to",   0, 3'b010, 32'h40, 0, 3, -1, 0);
      run_txn("lw_last", 0, 3'b010, 32'h44, 0, 1, TO - 1, 32'hCAFEF00D);
      run_txn("lh_neg",  0, 3'b001, 32'h22, 0, 2, 4, 32'h8001_7FFF);
      run_txn("ld_bad",  0, 3'b011, 32'h30, 0, 0, 0, 0);
      run_txn("st_bad",  1, 3'b100, 32'h30, 32'h1, 0, 0, 0);
      run_txn("sb3",     1, 3'b000, 32'h103, 32'hA5, 1, 0, 0);

      // Reset while a load sits in WAIT: outputs drop at once, no response.
      @(negedge clk);
      req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h80;
      @(negedge clk);
      req_valid = 0;
      mem_gnt = 1;
      @(negedge clk);
      mem_gnt = 0;
      check_eq("rstw.in_wait", {31'd0, stall}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rstw.mem_req", {31'd0, mem_req}, 32'd0);
      check_eq("rstw.stall", {31'd0, stall}, 32'd0);
      check_eq("rstw.ready", {31'd0, req_ready}, 32'd1);
      mem_rvalid = 1; mem_rdata = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rstw.no_resp", {31'd0, resp_valid}, 32'd0);
      end
      mem_rvalid = 0;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rstw.idle_after", {31'd0, resp_valid}, 32'd0);
      run_txn("post_rst", 0, 3'b101, 32'h86, 0, 0, 1, 32'hBEEF_0000);

      for (int t = 0; t < 200; t++) begin
         we = ($urandom_range(0, 2) == 0);
         pick = $urandom_range(0, 9);
         f3 = (pick < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom);
         a = $urandom;
         gd = $urandom_range(0, 4);
         pick = $urandom_range(0, 9);
         rd = (pick == 0) ? -1 : (pick == 1) ? TO - 1 : $urandom_range(0, 5);
         run_txn("rand", we, f3, a, $urandom, gd, rd, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
